hwpe_multi_subsystem: RTL and testbench

// Next-generation HWPE subsystem hub hosting N_HWPE engines behind one cluster config slave and one TCDM master port.

---
 rtl/hwpe_multi_subsystem.sv | 278 +++++++++++++++++++++++++++
 tb/tb_hwpe_multi_subsystem.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_multi_subsystem.sv
// hwpe_multi_subsystem: hub hosting N_HWPE engines behind one cluster config slave
// and one shared wide TCDM master port, with event OR-ing and busy aggregation.
module hwpe_multi_subsystem #(
  parameter int N_HWPE        = 2,
  parameter int N_CORES       = 8,
  parameter int N_MASTER_PORT = 9,
  parameter int ID_WIDTH      = 8,
  parameter int SEL_LSB       = 10,
  parameter int MAX_OUTST     = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  // cluster config slave
  input  logic                                  cfg_req_i,
  output logic                                  cfg_gnt_o,
  input  logic [31:0]                           cfg_add_i,
  input  logic [31:0]                           cfg_wdata_i,
  input  logic                                  cfg_wen_i,
  input  logic [3:0]                            cfg_be_i,
  input  logic [ID_WIDTH-1:0]                   cfg_id_i,
  output logic                                  cfg_r_valid_o,
  output logic [31:0]                           cfg_r_rdata_o,
  output logic [ID_WIDTH-1:0]                   cfg_r_id_o,
  // per-engine config ports
  output logic [N_HWPE-1:0]                     eng_cfg_req_o,
  output logic [31:0]                           eng_cfg_add_o,
  output logic                                  eng_cfg_wen_o,
  output logic [3:0]                            eng_cfg_be_o,
  output logic [31:0]                           eng_cfg_wdata_o,
  output logic [ID_WIDTH-1:0]                   eng_cfg_id_o,
  input  logic [N_HWPE-1:0]                     eng_cfg_gnt_i,
  input  logic [N_HWPE-1:0]                     eng_cfg_r_valid_i,
  input  logic [N_HWPE*32-1:0]                  eng_cfg_r_rdata_i,
  input  logic [N_HWPE*ID_WIDTH-1:0]            eng_cfg_r_id_i,
  // per-engine TCDM ports
  input  logic [N_HWPE-1:0]                     eng_tcdm_req_i,
  input  logic [N_HWPE*32-1:0]                  eng_tcdm_add_i,
  input  logic [N_HWPE-1:0]                     eng_tcdm_wen_i,
  input  logic [N_HWPE*N_MASTER_PORT*4-1:0]     eng_tcdm_be_i,
  input  logic [N_HWPE*N_MASTER_PORT*32-1:0]    eng_tcdm_data_i,
  output logic [N_HWPE-1:0]                     eng_tcdm_gnt_o,
  output logic [N_HWPE-1:0]                     eng_tcdm_r_valid_o,
  output logic [N_MASTER_PORT*32-1:0]           eng_tcdm_r_data_o,
  // shared TCDM master port
  output logic                                  tcdm_req_o,
  input  logic                                  tcdm_gnt_i,
  output logic [31:0]                           tcdm_add_o,
  output logic                                  tcdm_wen_o,
  output logic [N_MASTER_PORT*4-1:0]            tcdm_be_o,
  output logic [N_MASTER_PORT*32-1:0]           tcdm_data_o,
  input  logic                                  tcdm_r_valid_i,
  input  logic [N_MASTER_PORT*32-1:0]           tcdm_r_data_i,
  // events and busy
  input  logic [N_HWPE*N_CORES*2-1:0]           eng_evt_i,
  output logic [N_CORES*2-1:0]                  evt_o,
  input  logic [N_HWPE-1:0]                     eng_busy_i,
  output logic                                  busy_o
);

  localparam int BW  = N_MASTER_PORT*32;
  localparam int BEW = N_MASTER_PORT*4;
  localparam int EW  = N_CORES*2;
  localparam int SW  = (N_HWPE > 1) ? $clog2(N_HWPE) : 1;
  localparam int OCW = $clog2(MAX_OUTST+1);

  localparam logic [SW:0]     N_HWPE_W  = (SW+1)'(N_HWPE);
  localparam logic [SW-1:0]   LAST_ENG  = SW'(N_HWPE-1);
  localparam logic [OCW-1:0]  OUTST_MAX = OCW'(MAX_OUTST);
  localparam logic [31:0]     ERR_DATA  = 32'hBADC_0FFE;

  typedef enum logic {CFG_IDLE, CFG_WAIT} cfg_state_t;
  typedef enum logic [1:0] {T_IDLE, T_OWN, T_DRAIN} tcdm_state_t;

  // ---------------------------------------------------------------------------
  // Config demux
  // ---------------------------------------------------------------------------
  cfg_state_t            cfg_state, cfg_state_next;
  logic [SW-1:0]         sel, sel_q;
  logic                  sel_ok;
  logic                  err_valid, err_valid_next;
  logic [ID_WIDTH-1:0]   err_id;

  assign sel    = cfg_add_i[SEL_LSB +: SW];
  assign sel_ok = ({1'b0, sel} < N_HWPE_W);

  assign eng_cfg_add_o   = cfg_add_i;
  assign eng_cfg_wen_o   = cfg_wen_i;
  assign eng_cfg_be_o    = cfg_be_i;
  assign eng_cfg_wdata_o = cfg_wdata_i;
  assign eng_cfg_id_o    = cfg_id_i;

  // Route a config request to the selected engine, or answer it locally when no engine is there
  always_comb begin
    cfg_state_next = cfg_state;
    cfg_gnt_o      = 1'b0;
    eng_cfg_req_o  = '0;
    err_valid_next = 1'b0;
    case (cfg_state)
      CFG_IDLE: begin
        if (cfg_req_i) begin
          if (sel_ok) begin
            eng_cfg_req_o[sel] = 1'b1;
            cfg_gnt_o          = eng_cfg_gnt_i[sel];
            if (eng_cfg_gnt_i[sel]) begin
              cfg_state_next = CFG_WAIT;
            end
          end else begin
            cfg_gnt_o      = 1'b1;
            err_valid_next = 1'b1;
          end
        end
      end
      CFG_WAIT: begin
        if (eng_cfg_r_valid_i[sel_q]) begin
          cfg_state_next = CFG_IDLE;
        end
      end
      default: cfg_state_next = CFG_IDLE;
    endcase
  end

  // Response path: local error reply takes the cycle after its grant, otherwise the engine in flight answers
  always_comb begin
    cfg_r_valid_o = 1'b0;
    cfg_r_rdata_o = '0;
    cfg_r_id_o    = '0;
    if (err_valid) begin
      cfg_r_valid_o = 1'b1;
      cfg_r_rdata_o = ERR_DATA;
      cfg_r_id_o    = err_id;
    end else if (cfg_state == CFG_WAIT) begin
      cfg_r_valid_o = eng_cfg_r_valid_i[sel_q];
      cfg_r_rdata_o = eng_cfg_r_rdata_i[sel_q*32 +: 32];
      cfg_r_id_o    = eng_cfg_r_id_i[sel_q*ID_WIDTH +: ID_WIDTH];
    end
  end

  // Config state, latched engine select and pending local error reply
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cfg_state <= CFG_IDLE;
      sel_q     <= '0;
      err_valid <= 1'b0;
      err_id    <= '0;
    end else begin
      cfg_state <= cfg_state_next;
      err_valid <= err_valid_next;
      if (cfg_state == CFG_IDLE && cfg_req_i) begin
        sel_q  <= sel;
        err_id <= cfg_id_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // TCDM ownership
  // ---------------------------------------------------------------------------
  tcdm_state_t     t_state, t_state_next;
  logic [SW-1:0]   owner, owner_next, owner_inc;
  logic [SW-1:0]   rr_ptr, rr_ptr_next;
  logic [SW-1:0]   pick;
  logic            pick_valid;
  logic [OCW-1:0]  outst, outst_next;
  logic            outst_full, outst_empty;
  logic            req_fire, rsp_fire;
  int              idx;

  assign owner_inc   = (owner == LAST_ENG) ? '0 : owner + 1'b1;
  assign outst_full  = (outst == OUTST_MAX);
  assign outst_empty = (outst == '0);

  assign tcdm_add_o        = eng_tcdm_add_i[owner*32 +: 32];
  assign tcdm_wen_o        = eng_tcdm_wen_i[owner];
  assign tcdm_be_o         = eng_tcdm_be_i[owner*BEW +: BEW];
  assign tcdm_data_o       = eng_tcdm_data_i[owner*BW +: BW];
  assign eng_tcdm_r_data_o = tcdm_r_data_i;

  // Round-robin search: first requesting engine at or after rr_ptr, wrapping around
  always_comb begin
    pick       = rr_ptr;
    pick_valid = 1'b0;
    idx        = 0;
    for (int k = 0; k < N_HWPE; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_HWPE) begin
        idx = idx - N_HWPE;
      end
      if (!pick_valid && eng_tcdm_req_i[idx]) begin
        pick_valid = 1'b1;
        pick       = SW'(idx);
      end
    end
  end

  // Ownership FSM: arbitrate, let the owner drive the port, then drain its responses before handing over
  always_comb begin
    t_state_next       = t_state;
    owner_next         = owner;
    rr_ptr_next        = rr_ptr;
    tcdm_req_o         = 1'b0;
    eng_tcdm_gnt_o     = '0;
    eng_tcdm_r_valid_o = '0;
    case (t_state)
      T_IDLE: begin
        if (pick_valid) begin
          owner_next   = pick;
          t_state_next = T_OWN;
        end
      end
      T_OWN: begin
        tcdm_req_o                = eng_tcdm_req_i[owner] & ~outst_full;
        eng_tcdm_gnt_o[owner]     = tcdm_req_o & tcdm_gnt_i;
        eng_tcdm_r_valid_o[owner] = tcdm_r_valid_i & ~outst_empty;
        if (!(eng_tcdm_req_i[owner] | eng_busy_i[owner])) begin
          t_state_next = T_DRAIN;
        end
      end
      T_DRAIN: begin
        eng_tcdm_r_valid_o[owner] = tcdm_r_valid_i & ~outst_empty;
        if (outst_empty) begin
          t_state_next = T_IDLE;
          rr_ptr_next  = owner_inc;
        end
      end
      default: t_state_next = T_IDLE;
    endcase
  end

  assign req_fire = tcdm_req_o & tcdm_gnt_i;
  assign rsp_fire = tcdm_r_valid_i & ~outst_empty;

  // Outstanding counter: a grant and a response in the same cycle cancel out; stray responses are dropped
  always_comb begin
    outst_next = outst;
    case ({req_fire, rsp_fire})
      2'b10:   outst_next = outst + 1'b1;
      2'b01:   outst_next = outst - 1'b1;
      default: outst_next = outst;
    endcase
  end

  // TCDM state, owner, round-robin pointer and outstanding count
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      t_state <= T_IDLE;
      owner   <= '0;
      rr_ptr  <= '0;
      outst   <= '0;
    end else begin
      t_state <= t_state_next;
      owner   <= owner_next;
      rr_ptr  <= rr_ptr_next;
      outst   <= outst_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Events and busy
  // ---------------------------------------------------------------------------

  // Any engine raising an event line raises it towards the cores
  always_comb begin
    evt_o = '0;
    for (int i = 0; i < N_HWPE; i++) begin
      evt_o = evt_o | eng_evt_i[i*EW +: EW];
    end
  end

  // Busy when any engine is busy or the hub still holds a config or TCDM transaction
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_o <= 1'b0;
    end else begin
      busy_o <= (|eng_busy_i) | (t_state != T_IDLE) | (cfg_state == CFG_WAIT);
    end
  end

endmodule

// File: tb/tb_hwpe_multi_subsystem.sv
// tb_hwpe_multi_subsystem: directed scenarios plus random traffic against a behavioural model of the hub.
module tb_hwpe_multi_subsystem;

  localparam int N    = 3;
  localparam int NC   = 8;
  localparam int NMP  = 9;
  localparam int IDW  = 8;
  localparam int BW   = NMP*32;
  localparam int BEW  = NMP*4;
  localparam int EW   = NC*2;
  localparam int MAXO = 4;

  logic                 clk_i;
  logic                 rst_ni;
  logic                 cfg_req_i;
  logic                 cfg_gnt_o;
  logic [31:0]          cfg_add_i;
  logic [31:0]          cfg_wdata_i;
  logic                 cfg_wen_i;
  logic [3:0]           cfg_be_i;
  logic [IDW-1:0]       cfg_id_i;
  logic                 cfg_r_valid_o;
  logic [31:0]          cfg_r_rdata_o;
  logic [IDW-1:0]       cfg_r_id_o;
  logic [N-1:0]         eng_cfg_req_o;
  logic [31:0]          eng_cfg_add_o;
  logic                 eng_cfg_wen_o;
  logic [3:0]           eng_cfg_be_o;
  logic [31:0]          eng_cfg_wdata_o;
  logic [IDW-1:0]       eng_cfg_id_o;
  logic [N-1:0]         eng_cfg_gnt_i;
  logic [N-1:0]         eng_cfg_r_valid_i;
  logic [N*32-1:0]      eng_cfg_r_rdata_i;
  logic [N*IDW-1:0]     eng_cfg_r_id_i;
  logic [N-1:0]         eng_tcdm_req_i;
  logic [N*32-1:0]      eng_tcdm_add_i;
  logic [N-1:0]         eng_tcdm_wen_i;
  logic [N*BEW-1:0]     eng_tcdm_be_i;
  logic [N*BW-1:0]      eng_tcdm_data_i;
  logic [N-1:0]         eng_tcdm_gnt_o;
  logic [N-1:0]         eng_tcdm_r_valid_o;
  logic [BW-1:0]        eng_tcdm_r_data_o;
  logic                 tcdm_req_o;
  logic                 tcdm_gnt_i;
  logic [31:0]          tcdm_add_o;
  logic                 tcdm_wen_o;
  logic [BEW-1:0]       tcdm_be_o;
  logic [BW-1:0]        tcdm_data_o;
  logic                 tcdm_r_valid_i;
  logic [BW-1:0]        tcdm_r_data_i;
  logic [N*EW-1:0]      eng_evt_i;
  logic [EW-1:0]        evt_o;
  logic [N-1:0]         eng_busy_i;
  logic                 busy_o;

  int num_checks = 0;
  int num_fail   = 0;
  int gnt_seen   = 0;

  // reference model state
  bit             m_cfg_wait;
  int             m_cfg_sel;
  bit             m_err;
  logic [IDW-1:0] m_err_id;
  int             m_phase;
  int             m_owner;
  int             m_next;
  int             m_pending;
  bit             m_busy;

  hwpe_multi_subsystem #(
    .N_HWPE(N), .N_CORES(NC), .N_MASTER_PORT(NMP), .ID_WIDTH(IDW), .SEL_LSB(10), .MAX_OUTST(MAXO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_req_i(cfg_req_i), .cfg_gnt_o(cfg_gnt_o), .cfg_add_i(cfg_add_i), .cfg_wdata_i(cfg_wdata_i),
    .cfg_wen_i(cfg_wen_i), .cfg_be_i(cfg_be_i), .cfg_id_i(cfg_id_i),
    .cfg_r_valid_o(cfg_r_valid_o), .cfg_r_rdata_o(cfg_r_rdata_o), .cfg_r_id_o(cfg_r_id_o),
    .eng_cfg_req_o(eng_cfg_req_o), .eng_cfg_add_o(eng_cfg_add_o), .eng_cfg_wen_o(eng_cfg_wen_o),
    .eng_cfg_be_o(eng_cfg_be_o), .eng_cfg_wdata_o(eng_cfg_wdata_o), .eng_cfg_id_o(eng_cfg_id_o),
    .eng_cfg_gnt_i(eng_cfg_gnt_i), .eng_cfg_r_valid_i(eng_cfg_r_valid_i),
    .eng_cfg_r_rdata_i(eng_cfg_r_rdata_i), .eng_cfg_r_id_i(eng_cfg_r_id_i),
    .eng_tcdm_req_i(eng_tcdm_req_i), .eng_tcdm_add_i(eng_tcdm_add_i), .eng_tcdm_wen_i(eng_tcdm_wen_i),
    .eng_tcdm_be_i(eng_tcdm_be_i), .eng_tcdm_data_i(eng_tcdm_data_i),
    .eng_tcdm_gnt_o(eng_tcdm_gnt_o), .eng_tcdm_r_valid_o(eng_tcdm_r_valid_o),
    .eng_tcdm_r_data_o(eng_tcdm_r_data_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o), .tcdm_wen_o(tcdm_wen_o),
    .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o),
    .tcdm_r_valid_i(tcdm_r_valid_i), .tcdm_r_data_i(tcdm_r_data_i),
    .eng_evt_i(eng_evt_i), .evt_o(evt_o), .eng_busy_i(eng_busy_i), .busy_o(busy_o)
  );

  // free-running clock
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic checkOutput(input string tag, input logic [319:0] observed, input logic [319:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic clearInputs();
    rst_ni            = 1'b1;
    cfg_req_i         = 1'b0;
    cfg_add_i         = '0;
    cfg_wdata_i       = '0;
    cfg_wen_i         = 1'b0;
    cfg_be_i          = '0;
    cfg_id_i          = '0;
    eng_cfg_gnt_i     = '0;
    eng_cfg_r_valid_i = '0;
    eng_cfg_r_rdata_i = '0;
    eng_cfg_r_id_i    = '0;
    eng_tcdm_req_i    = '0;
    eng_tcdm_add_i    = '0;
    eng_tcdm_wen_i    = '0;
    eng_tcdm_be_i     = '0;
    eng_tcdm_data_i   = '0;
    tcdm_gnt_i        = 1'b0;
    tcdm_r_valid_i    = 1'b0;
    tcdm_r_data_i     = '0;
    eng_evt_i         = '0;
    eng_busy_i        = '0;
  endtask

  task automatic applyStimulus();
    rst_ni            = ($urandom_range(0, 199) != 0);
    cfg_req_i         = ($urandom_range(0, 2) == 0);
    cfg_add_i         = $urandom;
    cfg_wdata_i       = $urandom;
    cfg_wen_i         = 1'($urandom);
    cfg_be_i          = 4'($urandom);
    cfg_id_i          = IDW'($urandom);
    eng_cfg_gnt_i     = N'($urandom);
    eng_cfg_r_valid_i = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
    for (int i = 0; i < N; i++) begin
      eng_cfg_r_rdata_i[i*32 +: 32] = $urandom;
      eng_cfg_r_id_i[i*IDW +: IDW]  = IDW'($urandom);
      eng_tcdm_add_i[i*32 +: 32]    = $urandom;
    end
    eng_tcdm_req_i = N'($urandom);
    eng_tcdm_wen_i = N'($urandom);
    for (int b = 0; b < N*BEW; b++) eng_tcdm_be_i[b] = 1'($urandom);
    for (int w = 0; w < N*NMP; w++) eng_tcdm_data_i[w*32 +: 32] = $urandom;
    for (int w = 0; w < NMP; w++) tcdm_r_data_i[w*32 +: 32] = $urandom;
    tcdm_gnt_i     = ($urandom_range(0, 3) != 0);
    tcdm_r_valid_i = ($urandom_range(0, 2) == 0);
    eng_evt_i      = '0;
    for (int e = 0; e < 3; e++) eng_evt_i[$urandom_range(0, N*EW-1)] = 1'b1;
    eng_busy_i     = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
  endtask

  // compare every output against what the model predicts for the current inputs
  task automatic evalCycle();
    int             sel;
    logic [N-1:0]   exp_vec;
    logic [EW-1:0]  exp_evt;
    bit             exp_gnt;
    bit             exp_valid;
    bit             exp_req;
    #1;
    sel = int'(cfg_add_i[11:10]);
    exp_vec = '0;
    exp_gnt = 1'b0;
    if (!m_cfg_wait && cfg_req_i) begin
      if (sel >= N) begin
        exp_gnt = 1'b1;
      end else begin
        exp_vec[sel] = 1'b1;
        exp_gnt      = eng_cfg_gnt_i[sel];
      end
    end
    checkOutput("eng_cfg_req", eng_cfg_req_o, exp_vec);
    checkOutput("cfg_gnt", cfg_gnt_o, exp_gnt);
    checkOutput("eng_cfg_add", eng_cfg_add_o, cfg_add_i);
    checkOutput("eng_cfg_id", eng_cfg_id_o, cfg_id_i);
    exp_valid = m_err || (m_cfg_wait && eng_cfg_r_valid_i[m_cfg_sel]);
    checkOutput("cfg_r_valid", cfg_r_valid_o, exp_valid);
    if (m_err) begin
      checkOutput("cfg_err_rdata", cfg_r_rdata_o, 32'hBADC0FFE);
      checkOutput("cfg_err_id", cfg_r_id_o, m_err_id);
    end else if (exp_valid) begin
      checkOutput("cfg_r_rdata", cfg_r_rdata_o, eng_cfg_r_rdata_i[m_cfg_sel*32 +: 32]);
      checkOutput("cfg_r_id", cfg_r_id_o, eng_cfg_r_id_i[m_cfg_sel*IDW +: IDW]);
    end

    exp_req = (m_phase == 1) && eng_tcdm_req_i[m_owner] && (m_pending < MAXO);
    checkOutput("tcdm_req", tcdm_req_o, exp_req);
    exp_vec = '0;
    if (exp_req && tcdm_gnt_i) exp_vec[m_owner] = 1'b1;
    checkOutput("eng_tcdm_gnt", eng_tcdm_gnt_o, exp_vec);
    if (exp_req) begin
      checkOutput("tcdm_add", tcdm_add_o, eng_tcdm_add_i[m_owner*32 +: 32]);
      checkOutput("tcdm_wen", tcdm_wen_o, eng_tcdm_wen_i[m_owner]);
      checkOutput("tcdm_be", tcdm_be_o, eng_tcdm_be_i[m_owner*BEW +: BEW]);
      checkOutput("tcdm_data", tcdm_data_o, eng_tcdm_data_i[m_owner*BW +: BW]);
    end
    exp_vec = '0;
    if (m_phase != 0 && tcdm_r_valid_i && m_pending > 0) exp_vec[m_owner] = 1'b1;
    checkOutput("eng_tcdm_r_valid", eng_tcdm_r_valid_o, exp_vec);
    if (tcdm_r_valid_i) checkOutput("eng_tcdm_r_data", eng_tcdm_r_data_o, tcdm_r_data_i);

    exp_evt = '0;
    for (int i = 0; i < N; i++) exp_evt = exp_evt | eng_evt_i[i*EW +: EW];
    checkOutput("evt", evt_o, exp_evt);
    checkOutput("busy", busy_o, m_busy);
    if (eng_tcdm_gnt_o != '0) gnt_seen++;
  endtask

  // advance the model by one clock using the inputs that were applied for this cycle
  task automatic updateModel();
    int sel;
    bit new_busy;
    bit new_err;
    bit granted;
    bit answered;
    int old_pending;
    if (!rst_ni) begin
      m_cfg_wait = 1'b0;
      m_cfg_sel  = 0;
      m_err      = 1'b0;
      m_phase    = 0;
      m_owner    = 0;
      m_next     = 0;
      m_pending  = 0;
      m_busy     = 1'b0;
      return;
    end
    sel      = int'(cfg_add_i[11:10]);
    new_busy = (|eng_busy_i) || (m_phase != 0) || m_cfg_wait;
    new_err  = 1'b0;
    if (!m_cfg_wait) begin
      if (cfg_req_i) begin
        if (sel >= N) begin
          new_err  = 1'b1;
          m_err_id = cfg_id_i;
        end else if (eng_cfg_gnt_i[sel]) begin
          m_cfg_wait = 1'b1;
          m_cfg_sel  = sel;
        end
      end
    end else if (eng_cfg_r_valid_i[m_cfg_sel]) begin
      m_cfg_wait = 1'b0;
    end
    m_err = new_err;

    granted     = (m_phase == 1) && eng_tcdm_req_i[m_owner] && (m_pending < MAXO) && tcdm_gnt_i;
    answered    = tcdm_r_valid_i && (m_pending > 0);
    old_pending = m_pending;
    m_pending   = m_pending + int'(granted) - int'(answered);
    case (m_phase)
      0: begin
        for (int k = 0; k < N; k++) begin
          int e;
          e = (m_next + k) % N;
          if (eng_tcdm_req_i[e]) begin
            m_owner = e;
            m_phase = 1;
            break;
          end
        end
      end
      1: if (!eng_tcdm_req_i[m_owner] && !eng_busy_i[m_owner]) m_phase = 2;
      default: begin
        if (old_pending == 0) begin
          m_phase = 0;
          m_next  = (m_owner + 1) % N;
        end
      end
    endcase
    m_busy = new_busy;
  endtask

  task automatic advance();
    @(posedge clk_i);
    updateModel();
    @(negedge clk_i);
  endtask

  task automatic resetCycle();
    clearInputs();
    rst_ni = 1'b0;
    evalCycle();
    advance();
    rst_ni = 1'b1;
  endtask

  initial begin
    // unchecked first edge: DUT flops are unknown until reset is sampled
    clearInputs();
    rst_ni = 1'b0;
    @(negedge clk_i);
    @(posedge clk_i);
    updateModel();
    @(negedge clk_i);

    // reset state
    resetCycle();
    evalCycle();
    checkOutput("reset_busy", busy_o, 1'b0);
    checkOutput("reset_tcdm_req", tcdm_req_o, 1'b0);
    checkOutput("reset_cfg_r_valid", cfg_r_valid_o, 1'b0);
    advance();

    // config write to engine 1, granted immediately, answered one cycle later
    cfg_req_i = 1'b1; cfg_add_i = 32'h0000_0400; cfg_wen_i = 1'b0; cfg_id_i = 8'h5A;
    cfg_wdata_i = 32'hCAFE_0001; cfg_be_i = 4'hF; eng_cfg_gnt_i = 3'b010;
    evalCycle();
    checkOutput("cfg1_eng_req", eng_cfg_req_o, 3'b010);
    checkOutput("cfg1_gnt", cfg_gnt_o, 1'b1);
    advance();
    cfg_req_i = 1'b0; eng_cfg_gnt_i = '0; eng_cfg_r_valid_i = 3'b010;
    eng_cfg_r_id_i[15:8] = 8'h5A; eng_cfg_r_rdata_i[63:32] = 32'h1234_5678;
    evalCycle();
    checkOutput("cfg1_r_valid", cfg_r_valid_o, 1'b1);
    checkOutput("cfg1_r_id", cfg_r_id_o, 8'h5A);
    checkOutput("cfg1_r_rdata", cfg_r_rdata_o, 32'h1234_5678);
    advance();
    eng_cfg_r_valid_i = '0;

    // config access to a missing engine
    cfg_req_i = 1'b1; cfg_add_i = 32'h0000_0C00; cfg_id_i = 8'h33; eng_cfg_gnt_i = 3'b111;
    evalCycle();
    checkOutput("cfgerr_eng_req", eng_cfg_req_o, 3'b000);
    checkOutput("cfgerr_gnt", cfg_gnt_o, 1'b1);
    advance();
    cfg_req_i = 1'b0; eng_cfg_gnt_i = '0;
    evalCycle();
    checkOutput("cfgerr_r_valid", cfg_r_valid_o, 1'b1);
    checkOutput("cfgerr_rdata", cfg_r_rdata_o, 32'hBADC0FFE);
    checkOutput("cfgerr_r_id", cfg_r_id_o, 8'h33);
    advance();

    // engines 0 and 1 request together: engine 0 owns, drains two responses, then engine 1
    resetCycle();
    eng_tcdm_req_i = 3'b011; tcdm_gnt_i = 1'b1;
    eng_tcdm_add_i[31:0] = 32'h1000_0000; eng_tcdm_add_i[63:32] = 32'h2000_0000;
    evalCycle();
    checkOutput("arb_no_gnt", eng_tcdm_gnt_o, 3'b000);
    advance();
    for (int c = 0; c < 2; c++) begin
      evalCycle();
      checkOutput("eng0_gnt", eng_tcdm_gnt_o, 3'b001);
      advance();
    end
    eng_tcdm_req_i = 3'b010;
    evalCycle();
    advance();
    tcdm_r_valid_i = 1'b1;
    evalCycle();
    checkOutput("drain_r_valid", eng_tcdm_r_valid_o, 3'b001);
    advance();
    evalCycle();
    advance();
    tcdm_r_valid_i = 1'b0;
    evalCycle();
    advance();
    evalCycle();
    checkOutput("arb_eng1_no_req", tcdm_req_o, 1'b0);
    advance();
    evalCycle();
    checkOutput("eng1_gnt", eng_tcdm_gnt_o, 3'b010);
    advance();
    evalCycle();
    advance();

    // reset while engine 1 owns the port with two requests outstanding
    rst_ni = 1'b0;
    evalCycle();
    advance();
    rst_ni = 1'b1; eng_tcdm_req_i = 3'b011; tcdm_r_valid_i = 1'b1;
    evalCycle();
    checkOutput("rst_busy", busy_o, 1'b0);
    checkOutput("rst_tcdm_req", tcdm_req_o, 1'b0);
    checkOutput("rst_r_valid_dropped", eng_tcdm_r_valid_o, 3'b000);
    advance();
    tcdm_r_valid_i = 1'b0;
    evalCycle();
    checkOutput("rst_rr_eng0", eng_tcdm_gnt_o, 3'b001);
    advance();

    // outstanding limit: grants stop at four without responses
    resetCycle();
    eng_tcdm_req_i = 3'b001; tcdm_gnt_i = 1'b1;
    gnt_seen = 0;
    for (int c = 0; c < 10; c++) begin
      evalCycle();
      advance();
    end
    checkOutput("grant_limit", 32'(gnt_seen), 32'd4);
    tcdm_r_valid_i = 1'b1;
    evalCycle();
    checkOutput("full_still_blocked", tcdm_req_o, 1'b0);
    advance();
    tcdm_r_valid_i = 1'b0;
    evalCycle();
    checkOutput("resume_after_resp", tcdm_req_o, 1'b1);
    advance();

    // grant and response together at three outstanding keep the count at three
    tcdm_r_valid_i = 1'b1;
    evalCycle();
    advance();
    evalCycle();
    advance();
    tcdm_r_valid_i = 1'b0; tcdm_gnt_i = 1'b0;
    evalCycle();
    checkOutput("outst3_req", tcdm_req_o, 1'b1);
    advance();
    tcdm_gnt_i = 1'b1;
    evalCycle();
    advance();
    evalCycle();
    checkOutput("outst4_blocked", tcdm_req_o, 1'b0);
    advance();

    // events are OR-ed combinationally
    eng_evt_i = '0;
    eng_evt_i[0] = 1'b1;
    eng_evt_i[EW+5] = 1'b1;
    evalCycle();
    checkOutput("evt_or", evt_o, 16'h0021);
    advance();

    // random traffic
    resetCycle();
    for (int c = 0; c < 3000; c++) begin
      applyStimulus();
      evalCycle();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
